// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
//
// Multiplexed scan driver for a 4-digit, 7-segment, common-anode-style
// display with active-low segment and digit-enable lines.
//
// Each digit owns a fixed-length slot of BLANK_CYCLES + 8*ON_UNIT cycles:
//   BLANK : BLANK_CYCLES dark guard cycles (ghosting protection)
//   ON    : (b+1)*ON_UNIT cycles with the digit lit
//   OFF   : (7-b)*ON_UNIT dark cycles (skipped when b = 7)
// b is the brightness level sampled on entry to BLANK, so the slot length
// never changes, and so neither does the frame rate.
//
// Digit values are double-buffered. Writes land in a shadow bank. A swap
// request arms a commit, and the commit copies shadow into active at the
// end of the digit-3 slot, so a frame never mixes old and new values.
//
// Ports
//   clk            in   1  sole clock, rising edge
//   reset          in   1  asynchronous, active-high
//   wr_valid       in   1  shadow write request
//   wr_ready       out  1  shadow bank accepts a write (0 while a commit pends)
//   wr_digit       in   2  shadow digit index 0..3
//   wr_value       in   5  0-9 numeral, 10 dash, 11-31 blank
//   swap_req       in   1  single-cycle commit request
//   swap_pending   out  1  commit armed, not yet performed
//   brightness     in   3  on-time level, 0 = 1/8 .. 7 = 8/8
//   segment_       out  7  active-low segments, bit order gfedcba
//   digit_enable_  out  4  active-low one-hot digit enable
//   frame_done     out  1  pulse in the last cycle of the digit-3 slot
// ---------------------------------------------------------------------------
module display_scan_controller #(
    parameter int BLANK_CYCLES = 32,
    parameter int ON_UNIT      = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [4:0] wr_value,
    input  logic       swap_req,
    output logic       swap_pending,
    input  logic [2:0] brightness,
    output logic [6:0] segment_,
    output logic [3:0] digit_enable_,
    output logic       frame_done
);

    localparam int SLOT_LEN = BLANK_CYCLES + 8 * ON_UNIT;
    localparam int CNT_RAW  = $clog2(SLOT_LEN + 1);
    localparam int CNT_W    = (CNT_RAW < 4) ? 4 : CNT_RAW;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;

    localparam logic [4:0]       CODE_BLANK = 5'd11;
    localparam logic [6:0]       SEG_DARK   = 7'h7F;
    localparam logic [3:0]       EN_DARK    = 4'hF;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_U       = CNT_W'(ON_UNIT);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Terminal counter value of the ON phase for brightness level b.
    function automatic logic [CNT_W-1:0] on_last(input logic [2:0] b);
        on_last = ON_U * (CNT_W'(b) + CNT_W'(1)) - CNT_W'(1);
    endfunction

    // Terminal counter value of the OFF phase; never consulted when b = 7.
    function automatic logic [CNT_W-1:0] off_last(input logic [2:0] b);
        off_last = ON_U * (CNT_W'(7) - CNT_W'(b)) - CNT_W'(1);
    endfunction

    // Digit code to active-low segment pattern (gfedcba).
    function automatic logic [6:0] seg_encode(input logic [4:0] code);
        logic [6:0] lit;
        case (code)
            5'd0:    lit = 7'b0111111;
            5'd1:    lit = 7'b0000110;
            5'd2:    lit = 7'b1011011;
            5'd3:    lit = 7'b1001111;
            5'd4:    lit = 7'b1100110;
            5'd5:    lit = 7'b1101101;
            5'd6:    lit = 7'b1111101;
            5'd7:    lit = 7'b0000111;
            5'd8:    lit = 7'b1111111;
            5'd9:    lit = 7'b1101111;
            5'd10:   lit = 7'b1000000;
            default: lit = 7'b0000000;
        endcase
        seg_encode = ~lit;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_digit;
    logic [2:0]       r_b;
    logic             r_run;
    logic             r_swap_pending;
    logic             r_wr_ready;
    logic             r_frame_done;
    logic [3:0]       r_den;
    logic [6:0]       r_seg;
    logic [4:0]       r_active [4];
    logic [4:0]       r_shadow [4];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic [1:0]       w_nstate;
    logic [CNT_W-1:0] w_ncnt;
    logic [1:0]       w_ndigit;
    logic [2:0]       w_nb;
    logic             w_slot_end;
    logic             w_nlast;
    logic             w_commit;
    logic             w_npend;
    logic             w_wr_fire;

    always_comb begin
        w_nstate   = r_state;
        w_ncnt     = r_cnt + 1'b1;
        w_ndigit   = r_digit;
        w_nb       = r_b;
        w_slot_end = 1'b0;

        if (!r_run) begin
            // First edge after reset enters BLANK of digit 0; this edge
            // counts as slot entry, so brightness is sampled here too.
            w_nstate = ST_BLANK;
            w_ncnt   = '0;
            w_ndigit = 2'd0;
            w_nb     = brightness;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_nstate = ST_ON;
                        w_ncnt   = '0;
                    end
                end
                ST_ON: begin
                    if (r_cnt == on_last(r_b)) begin
                        w_ncnt = '0;
                        if (r_b == 3'd7) begin
                            w_slot_end = 1'b1;
                        end else begin
                            w_nstate = ST_OFF;
                        end
                    end
                end
                ST_OFF: begin
                    if (r_cnt == off_last(r_b)) begin
                        w_slot_end = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: restart the slot sequence.
                    w_slot_end = 1'b1;
                end
            endcase

            if (w_slot_end) begin
                w_nstate = ST_BLANK;
                w_ncnt   = '0;
                w_ndigit = r_digit + 2'd1;
                w_nb     = brightness;
            end
        end
    end

    // The next cycle is the last one of its slot. Outputs are registered
    // from the next state so they line up with the state they describe.
    always_comb begin
        w_nlast = 1'b0;
        if (w_nstate == ST_ON && w_nb == 3'd7 && w_ncnt == on_last(w_nb)) begin
            w_nlast = 1'b1;
        end
        if (w_nstate == ST_OFF && w_ncnt == off_last(w_nb)) begin
            w_nlast = 1'b1;
        end
    end

    // r_frame_done marks the current cycle as the frame boundary, so the
    // commit happens on the edge that closes the digit-3 slot.
    assign w_commit  = r_frame_done & r_swap_pending;

    // A commit clears the pending flag, but a request arriving in the same
    // boundary cycle re-arms it for the next frame.
    assign w_npend   = w_commit ? swap_req : (r_swap_pending | swap_req);

    assign w_wr_fire = wr_valid & r_wr_ready;

    // -----------------------------------------------------------------------
    // Scan state, handshake and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_BLANK;
            r_cnt          <= '0;
            r_digit        <= 2'd0;
            r_b            <= 3'd0;
            r_run          <= 1'b0;
            r_swap_pending <= 1'b0;
            r_wr_ready     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_den          <= EN_DARK;
            r_seg          <= SEG_DARK;
        end else begin
            r_state        <= w_nstate;
            r_cnt          <= w_ncnt;
            r_digit        <= w_ndigit;
            r_b            <= w_nb;
            r_run          <= 1'b1;
            r_swap_pending <= w_npend;
            r_wr_ready     <= ~w_npend;
            r_frame_done   <= w_nlast & (w_ndigit == 2'd3);
            if (w_nstate == ST_ON) begin
                r_den <= ~(4'b0001 << w_ndigit);
                // The active bank only changes on a boundary edge, and the
                // next state then is BLANK, so reading it here is safe.
                r_seg <= seg_encode(r_active[w_ndigit]);
            end else begin
                r_den <= EN_DARK;
                r_seg <= SEG_DARK;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shadow and active digit banks
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= CODE_BLANK;
                r_shadow[i] <= CODE_BLANK;
            end
        end else begin
            if (w_commit) begin
                r_active <= r_shadow;
            end
            // Writes are blocked while a commit is pending, so a write and a
            // commit never coincide on the same edge.
            if (w_wr_fire) begin
                r_shadow[wr_digit] <= wr_value;
            end
        end
    end

    assign wr_ready      = r_wr_ready;
    assign swap_pending  = r_swap_pending;
    assign segment_      = r_seg;
    assign digit_enable_ = r_den;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_display_scan_controller
//
// Bench for display_scan_controller with BLANK_CYCLES=2, ON_UNIT=4.
// A timeline model tracks the cycle index since the first edge after reset
// and derives every output from slot/phase arithmetic and a two-bank value
// model. A compare process checks the DUT against it on every falling edge,
// together with a one-hot / dark-gap checker. Directed scenarios add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int BL    = 2;
    localparam int OU    = 4;
    localparam int SLOT  = BL + 8 * OU;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [4:0] wr_value;
    logic       swap_req;
    logic       swap_pending;
    logic [2:0] brightness;
    logic [6:0] segment_;
    logic [3:0] digit_enable_;
    logic       frame_done;

    always #5 clk = ~clk;

    display_scan_controller #(
        .BLANK_CYCLES (BL),
        .ON_UNIT      (OU)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_digit      (wr_digit),
        .wr_value      (wr_value),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
        .brightness    (brightness),
        .segment_      (segment_),
        .digit_enable_ (digit_enable_),
        .frame_done    (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Active-high patterns for each code, inverted for the active-low pins.
    function automatic logic [6:0] seg_of(input int code);
        logic [6:0] pat;
        case (code)
            0:       pat = 7'b0111111;
            1:       pat = 7'b0000110;
            2:       pat = 7'b1011011;
            3:       pat = 7'b1001111;
            4:       pat = 7'b1100110;
            5:       pat = 7'b1101101;
            6:       pat = 7'b1111101;
            7:       pat = 7'b0000111;
            8:       pat = 7'b1111111;
            9:       pat = 7'b1101111;
            10:      pat = 7'b1000000;
            default: pat = 7'b0000000;
        endcase
        return ~pat;
    endfunction

    function automatic int den_to_digit(input logic [3:0] den);
        case (den)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            default: return -1;
        endcase
    endfunction

    // ---------------- timeline model ----------------
    bit m_run   = 1'b0;
    int t       = 0;
    int m_b     = 0;
    bit m_pend  = 1'b0;
    bit m_ready = 1'b0;
    int m_act [4];
    int m_sh  [4];

    task automatic model_step();
        bit commit;
        if (reset) begin
            m_run   = 1'b0;
            t       = 0;
            m_b     = 0;
            m_pend  = 1'b0;
            m_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_act[i] = 11;
                m_sh[i]  = 11;
            end
        end else begin
            commit = m_run && (t % FRAME == FRAME - 1) && m_pend;
            if (commit) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            end
            if (wr_valid && m_ready) m_sh[wr_digit] = int'(wr_value);
            m_pend  = commit ? swap_req : (m_pend || swap_req);
            m_ready = !m_pend;
            if (!m_run) begin
                m_run = 1'b1;
                t     = 0;
            end else begin
                t++;
            end
            if (t % SLOT == 0) m_b = int'(brightness);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // ---------------- per-cycle compare and scan-safety checker ----------------
    int last_d   = -1;
    int dark_run = 0;

    initial begin
        logic [3:0] e_den;
        logic [6:0] e_seg;
        logic       e_fd;
        int         off;
        int         dig;
        int         d;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_den = 4'hF;
                e_seg = 7'h7F;
                e_fd  = 1'b0;
                if (!reset && m_run) begin
                    off = t % SLOT;
                    dig = (t / SLOT) % 4;
                    if (off >= BL && off < BL + (m_b + 1) * OU) begin
                        e_den = ~(4'b0001 << dig);
                        e_seg = seg_of(m_act[dig]);
                    end
                    e_fd = (t % FRAME == FRAME - 1);
                end
                chk("model_enable", digit_enable_, e_den);
                chk("model_segment", segment_, e_seg);
                chk("model_frame_done", frame_done, e_fd);
                chk("model_swap_pending", swap_pending, m_pend);
                chk("model_wr_ready", wr_ready, m_ready);

                chk("enable_onehot", digit_enable_ inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}, 1);
                d = den_to_digit(digit_enable_);
                if (d < 0) begin
                    dark_run++;
                end else begin
                    if (last_d >= 0 && d != last_d) chk("dark_gap_ok", dark_run >= BL, 1);
                    last_d   = d;
                    dark_run = 0;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int         cap_en [4];
    logic [6:0] cap_seg [4];
    int         cap_fd_n;
    int         cap_fd_idx;
    int         cap_first_on;
    bit         cap_order_ok;

    // Record one frame from index `first` to FRAME-1 (one sample per cycle).
    task automatic capture(input int first);
        int d;
        for (int k = 0; k < 4; k++) begin
            cap_en[k]  = 0;
            cap_seg[k] = 7'h00;
        end
        cap_fd_n     = 0;
        cap_fd_idx   = -1;
        cap_first_on = -1;
        cap_order_ok = 1'b1;
        for (int i = first; i < FRAME; i++) begin
            @(negedge clk);
            d = den_to_digit(digit_enable_);
            if (d >= 0) begin
                cap_en[d]++;
                cap_seg[d] = segment_;
                if (cap_first_on < 0) cap_first_on = i;
                if (d != i / SLOT) cap_order_ok = 1'b0;
            end
            if (frame_done) begin
                cap_fd_n++;
                cap_fd_idx = i;
            end
        end
    endtask

    task automatic wait_fd(input string name, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (frame_done === 1'b1 || cycles >= 2 * FRAME) break;
        end
        chk(name, frame_done, 1);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        wr_valid   = 1'b0;
        wr_digit   = 2'd0;
        wr_value   = 5'd0;
        swap_req   = 1'b0;
        brightness = 3'd7;

        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_enable", digit_enable_, 4'hF);
        chk("rst_segment", segment_, 7'h7F);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_swap_pending", swap_pending, 0);
        chk("rst_wr_ready", wr_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", wr_ready, 1);

        // Digits 1,2,3,4 at full brightness, committed at the first boundary.
        for (int d = 0; d < 4; d++) begin
            wr_valid = 1'b1;
            wr_digit = 2'(d);
            wr_value = 5'(d + 1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("swap_pending_set", swap_pending, 1);
        chk("wr_ready_blocked", wr_ready, 0);
        wait_fd("fd_first_frame", n);
        chk("fd_first_latency", n, FRAME - 6);
        capture(0);
        chk("b7_digit0_on", cap_en[0], 32);
        chk("b7_digit3_on", cap_en[3], 32);
        chk("b7_first_on", cap_first_on, 2);
        chk("b7_seg_d0", cap_seg[0], 7'h79);
        chk("b7_seg_d1", cap_seg[1], 7'h24);
        chk("b7_seg_d2", cap_seg[2], 7'h30);
        chk("b7_seg_d3", cap_seg[3], 7'h19);
        chk("b7_order", cap_order_ok, 1);
        chk("b7_fd_idx", cap_fd_idx, FRAME - 1);
        chk("b7_pending_cleared", swap_pending, 0);

        // Minimum brightness from the next slot entry (the boundary edge).
        brightness = 3'd0;
        capture(0);
        chk("b0_digit0_on", cap_en[0], 4);
        chk("b0_digit2_on", cap_en[2], 4);
        chk("b0_first_on", cap_first_on, 2);
        chk("b0_fd_count", cap_fd_n, 1);
        chk("b0_fd_idx", cap_fd_idx, FRAME - 1);
        chk("b0_seg_d1", cap_seg[1], 7'h24);
        wait_fd("fd_period_seen", n);
        chk("fd_period", n, 136);

        // Write+swap together, then a write that must be dropped.
        brightness = 3'd7;
        repeat (40) @(negedge clk);
        wr_valid = 1'b1;
        wr_digit = 2'd0;
        wr_value = 5'd7;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("pend_after_wr_swap", swap_pending, 1);
        chk("ready_after_wr_swap", wr_ready, 0);
        wr_digit = 2'd1;
        wr_value = 5'd8;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_fd("fd_commit1", n);
        chk("pend_at_boundary", swap_pending, 1);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("pend_rearmed", swap_pending, 1);
        capture(1);
        chk("commit_seg_d0", cap_seg[0], 7'h78);
        chk("dropped_seg_d1", cap_seg[1], 7'h24);
        chk("commit_digit0_on", cap_en[0], 32);
        chk("pend_before_commit2", swap_pending, 1);
        @(negedge clk);
        chk("pend_after_commit2", swap_pending, 0);
        chk("ready_after_commit2", wr_ready, 1);

        // Asynchronous reset in the middle of digit 0's ON phase.
        n = 0;
        while (digit_enable_ !== 4'hE && n < 2 * SLOT) begin
            @(negedge clk);
            n++;
        end
        chk("reached_on", digit_enable_, 4'hE);
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_enable", digit_enable_, 4'hF);
        chk("async_rst_segment", segment_, 7'h7F);
        chk("async_rst_ready", wr_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        capture(0);
        chk("post_rst_seg_d0", cap_seg[0], 7'h7F);
        chk("post_rst_seg_d3", cap_seg[3], 7'h7F);
        chk("post_rst_digit0_on", cap_en[0], 32);
        chk("post_rst_first_on", cap_first_on, 2);
        chk("post_rst_order", cap_order_ok, 1);
        chk("post_rst_fd_idx", cap_fd_idx, FRAME - 1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
